// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MIPS-32 pipeline hazard controller.
//   state_e      : sequencer state (normal flow or waiting on data memory)
//   M_*          : bit positions of the M control field held in EX/MEM
//   PCSEL_*      : encodings of the PC-source select
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    localparam int unsigned M_BRANCH = 2;
    localparam int unsigned M_READ   = 1;
    localparam int unsigned M_WRITE  = 0;

    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Combinational load-use hazard compare.
//   idex_memread_i : instruction in ID/EX is a load
//   idex_rt_i      : destination register of that load
//   ifid_rs_i/rt_i : source registers of the instruction in IF/ID
//   hazard_o       : IF/ID instruction needs the load result next cycle
module load_use_detect (
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       hazard_o
);

    // $zero is never a real dependency.
    assign hazard_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS-32 core.
// Drives enables/flushes of PC, IF/ID, ID/EX, EX/MEM, MEM/WB and the PC-source select.
//   clk, rst_n          : clock, synchronous active-low reset
//   exmem_m/zero/jump   : control of the instruction in EX/MEM
//   idex_memread/rt     : load info of the instruction in ID/EX
//   ifid_rs/rt          : source registers of the instruction in IF/ID
//   dmem_ready/dmem_req : data-memory handshake
//   pc_write, pc_sel    : PC enable and source select
//   *_write, *_flush    : pipeline register enables and bubble inserts
//   mem_err             : sticky access-timeout flag
//   stall_cnt           : saturating count of cycles with pc_write=0
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       exmem_m,
    input  logic             exmem_zero,
    input  logic             exmem_jump,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e             state_q, state_d;
    logic [15:0]        wait_q, wait_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic mem_op;
    logic in_wait;
    logic timeout;
    logic mem_stall;
    logic take_branch;
    logic take_jump;
    logic hazard;

    load_use_detect u_load_use (
        .idex_memread_i (idex_memread),
        .idex_rt_i      (idex_rt),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .hazard_o       (hazard)
    );

    assign mem_op      = exmem_m[M_READ] | exmem_m[M_WRITE];
    assign in_wait     = (state_q == StMemWait);
    assign timeout     = in_wait && !dmem_ready && (wait_q == 16'(TIMEOUT));
    // A zero-wait access (ready with the request) never stalls.
    assign mem_stall   = (!in_wait && mem_op && !dmem_ready) ||
                         (in_wait && !dmem_ready && !timeout);
    assign take_branch = exmem_m[M_BRANCH] & exmem_zero;
    assign take_jump   = exmem_jump;

    // Output decode: memory stall > redirect > load-use > normal flow.
    always_comb begin
        dmem_req    = mem_op;
        pc_write    = 1'b1;
        pc_sel      = PCSEL_SEQ;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        if (mem_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else begin
            // Abandoned access still advances EX/MEM, but its result is dropped.
            if (timeout) begin
                memwb_flush = 1'b1;
            end
            if (take_branch || take_jump) begin
                pc_sel      = take_branch ? PCSEL_BRANCH : PCSEL_JUMP;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
            end
        end

        if (!rst_n) begin
            dmem_req    = 1'b0;
            pc_write    = 1'b0;
            pc_sel      = PCSEL_SEQ;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_write = 1'b0;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            StRun: begin
                if (mem_op && !dmem_ready) begin
                    state_d = StMemWait;
                    wait_d  = 16'd1;
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d = StRun;
                end else if (timeout) begin
                    state_d   = StRun;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = StRun;
        endcase

        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_q      <= 16'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;

    typedef struct packed {
        logic       dmem_req;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       ifid_write;
        logic       ifid_flush;
        logic       idex_flush;
        logic       exmem_write;
        logic       exmem_flush;
        logic       memwb_flush;
        logic       mem_err;
    } ctl_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       exmem_m;
    logic             exmem_zero;
    logic             exmem_jump;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_write;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_t             exp_q[$];
    string            tag_q[$];
    logic             exp_err;
    logic [CNT_W-1:0] exp_stall;

    pipe_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exmem_m      (exmem_m),
        .exmem_zero   (exmem_zero),
        .exmem_jump   (exmem_jump),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_write  (exmem_write),
        .exmem_flush  (exmem_flush),
        .memwb_flush  (memwb_flush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Expected-output builders; mem_err is filled in from exp_err when pushed.
    function automatic ctl_t c_norm(input logic req);
        c_norm = {req, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic ctl_t c_load(input logic req);
        c_load = {req, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic ctl_t c_mstall();
        c_mstall = {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic ctl_t c_redir(input logic [1:0] sel, input logic req);
        c_redir = {req, 1'b1, sel, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic ctl_t c_tmo();
        c_tmo = {1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic ctl_t c_rst();
        c_rst = {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    endfunction

    task automatic drive(input logic [2:0] m, input logic z, input logic j,
                         input logic imr, input logic [4:0] irt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic rdy);
        exmem_m      = m;
        exmem_zero   = z;
        exmem_jump   = j;
        idex_memread = imr;
        idex_rt      = irt;
        ifid_rs      = rs;
        ifid_rt      = rt;
        dmem_ready   = rdy;
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows now.
    task automatic check();
        ctl_t  e;
        ctl_t  obs;
        string tag;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        obs = {dmem_req, pc_write, pc_sel, ifid_write, ifid_flush, idex_flush,
               exmem_write, exmem_flush, memwb_flush, mem_err};
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s ctl: observed %b required %b", tag, obs, e);
        end
        n_checks++;
        assert (stall_cnt === exp_stall) else begin
            n_fail++;
            $error("FAIL %s stall_cnt: observed %0d required %0d", tag, stall_cnt, exp_stall);
        end
        // Registered effects of this cycle, visible from the next one.
        if (!rst_n) begin
            exp_stall = '0;
            exp_err   = 1'b0;
        end else if (!e.pc_write && exp_stall != {CNT_W{1'b1}}) begin
            exp_stall = exp_stall + 1'b1;
        end
    endtask

    task automatic step(input string tag, input ctl_t e);
        e.mem_err = exp_err;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_err   = 1'b0;
        exp_stall = '0;
        rst_n     = 1'b0;
        drive(3'b000, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        @(posedge clk);
        #1;

        step("reset", c_rst());
        rst_n = 1'b1;
        step("idle", c_norm(0));

        drive(3'b000, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        step("loaduse_rs", c_load(0));
        drive(3'b000, 0, 0, 0, 5'd5, 5'd5, 5'd0, 0);
        step("loaduse_bubble", c_norm(0));
        drive(3'b000, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        step("loaduse_r0", c_norm(0));
        drive(3'b000, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0);
        step("loaduse_rt", c_load(0));

        drive(3'b100, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("branch_taken", c_redir(2'b01, 0));
        drive(3'b100, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("branch_not", c_norm(0));
        drive(3'b000, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        step("jump_hazard", c_redir(2'b10, 0));
        drive(3'b100, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step("branch_jump", c_redir(2'b01, 0));
        drive(3'b010, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        step("zero_wait", c_norm(1));

        // Three wait cycles then completion.
        rst_n = 1'b0;
        step("reset2", c_rst());
        rst_n = 1'b1;
        drive(3'b010, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 3; i++) step("memwait", c_mstall());
        dmem_ready = 1'b1;
        step("mem_done", c_norm(1));
        drive(3'b000, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("after_mem", c_norm(0));

        // Ready held low: RUN stall plus TIMEOUT-1 waits, then abandoned.
        drive(3'b001, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 4; i++) step("tmo_wait", c_mstall());
        step("tmo_cycle", c_tmo());
        exp_err = 1'b1;
        drive(3'b000, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("err_sticky", c_norm(0));
        drive(3'b010, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        step("err_sticky2", c_norm(1));

        // Reset in the middle of a wait.
        drive(3'b010, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("midwait_run", c_mstall());
        step("midwait_wait", c_mstall());
        rst_n = 1'b0;
        step("midwait_rst", c_rst());
        rst_n = 1'b1;
        // Ready low with no access: stalls only if still in MEM_WAIT.
        drive(3'b000, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("post_rst_run", c_norm(0));

        // Saturation of the stall counter.
        drive(3'b000, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0);
        for (int i = 0; i < 18; i++) step("stall_sat", c_load(0));
        drive(3'b000, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("sat_hold", c_norm(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage MIPS-32 core. It generates write-enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken branches and jumps held in the EX/MEM register, and stalls on a multi-cycle data-memory req/ready handshake with timeout. It sits beside the pipeline registers and drives their enable/flush inputs plus the PC-source select.

Parameters:
TIMEOUT, 16, max MEM_WAIT cycles before an access is abandoned (valid range 1..65535)
CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
exmem_m  in  3  M field in EX/MEM: [2]=Branch, [1]=MemRead, [0]=MemWrite
exmem_zero  in  1  zero flag in EX/MEM
exmem_jump  in  1  jump instruction in EX/MEM
idex_memread  in  1  MemRead of instruction in ID/EX
idex_rt  in  5  rt of instruction in ID/EX
ifid_rs  in  5  rs field of instruction in IF/ID
ifid_rt  in  5  rt field of instruction in IF/ID
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data-memory access request
pc_write  out  1  PC load enable
pc_sel  out  2  00=PC+4, 01=branch target (Add_result), 10=jump address
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID loads bubble
idex_flush  out  1  ID/EX loads bubble (control fields zeroed)
exmem_write  out  1  EX/MEM enable
exmem_flush  out  1  EX/MEM loads bubble
memwb_flush  out  1  MEM/WB loads bubble
mem_err  out  1  sticky: an access timed out
stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset (rst_n=0 at a clk edge): state=RUN, wait counter=0, mem_err=0, stall_cnt=0. While rst_n is low, outputs are forced combinationally: all *_write=0, all *_flush=1, dmem_req=0, pc_sel=00.
- Outputs are combinational from the registered state and the current inputs. Counters and state update on the clk edge.
- mem_op = exmem_m[1] | exmem_m[0]. dmem_req = mem_op in RUN and in MEM_WAIT.
- FSM states: RUN, MEM_WAIT.
- Memory stall (priority 1):
  - Condition: RUN with mem_op & !dmem_ready, or MEM_WAIT with !dmem_ready.
  - Outputs: pc_write=0, ifid_write=0, exmem_write=0, memwb_flush=1; no other flushes.
  - RUN -> MEM_WAIT, wait counter cleared to 1. MEM_WAIT increments the counter.
  - A zero-wait access (ready in the same cycle) does not stall.
- Completion: dmem_ready=1 while dmem_req=1 -> the EX/MEM entry advances normally; MEM_WAIT -> RUN.
- Timeout: in MEM_WAIT with counter==TIMEOUT and !dmem_ready -> mem_err<=1, return to RUN. That cycle is treated as a completion with memwb_flush=1, so the result is dropped.
- Redirect (priority 2): evaluated only in a cycle where EX/MEM advances. If exmem_m[2]&exmem_zero, pc_sel=01. Else if exmem_jump, pc_sel=10. On a redirect:
  - pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - The load-use hazard is ignored.
  - Branch and jump both set -> branch wins.
- Load-use (priority 3): hazard = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1.
  - Lasts exactly one cycle per hazard, because the bubble clears idex_memread.
- Default: all writes=1, flushes=0, pc_sel=00.
- stall_cnt increments on every post-reset cycle with pc_write=0 and saturates at all-ones.
- mem_err clears only on reset.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT}
  - M bit indices (M_BRANCH=2, M_READ=1, M_WRITE=0)
  - pc_sel encodings PCSEL_SEQ/BRANCH/JUMP
- One natural sub-module: load_use_detect, the combinational hazard compare.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; idex_rt=0 -> no stall.
- Branch: exmem_m=100, zero=1 -> pc_sel=01, ifid/idex/exmem_flush=1 for one cycle; zero=0 -> pc_sel=00, no flush.
- Jump with simultaneous load-use: exmem_jump=1 plus hazard -> pc_sel=10, flushes asserted, pc_write=1.
- Memory wait: exmem_m=010, dmem_ready low for 3 cycles then high -> 3 stall cycles (memwb_flush=1), advance on the 4th, stall_cnt=3.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> mem_err=1 after the 4th MEM_WAIT cycle, FSM returns to RUN, mem_err stays 1.
- Reset mid-wait: rst_n=0 during MEM_WAIT -> next cycle state=RUN, stall_cnt=0, mem_err=0, dmem_req=0.
